// File: rtl/rv32_inst_encoder_loader.sv
// RV32I field-set encoder that streams packed words into IMEM; ENCODER_APPEND_HALT_EN appends an ECALL on finish.
// One-cycle accept-to-write latency at full rate; in_ready drops outside RUN, on finish, or once DEPTH words are written.
module rv32_inst_encoder_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count,
    output logic [ADDR_W:0]   word_count
);

`ifdef ENCODER_APPEND_HALT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [31:0]       ECALL    = 32'h0000_0073;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_err_count;
    logic [ADDR_W:0]     r_word_count;

    logic [31:0] w_sext12;
    logic [31:0] w_sext13;
    logic [31:0] w_sext21;
    logic        w_is_shift;
    logic        w_room;
    logic        w_ready;
    logic        w_accept;
    logic        w_reject;
    logic [31:0] w_word;

    assign w_sext12   = {{20{in_imm[11]}}, in_imm[11:0]};
    assign w_sext13   = {{19{in_imm[12]}}, in_imm[12:0]};
    assign w_sext21   = {{11{in_imm[20]}}, in_imm[20:0]};
    assign w_is_shift = (in_opcode == 7'b0010011) &&
                        ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
    // word_count already includes the word being written, so this cannot overshoot DEPTH.
    assign w_room     = (r_word_count < DEPTH_W);
    assign w_ready    = (r_state == S_RUN) && w_room && !finish;
    assign w_accept   = in_valid && w_ready;

    always_comb begin
        w_word   = 32'h0;
        w_reject = 1'b0;
        case (in_class)
            3'd0: begin
                w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            3'd1: begin
                if (w_is_shift) begin
                    w_word   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_reject = |in_imm[31:5];
                end else begin
                    w_word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_reject = (in_imm != w_sext12);
                end
            end
            3'd2: begin
                w_word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_reject = (in_imm != w_sext12);
            end
            3'd3: begin
                w_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                w_reject = (in_imm != w_sext13) || in_imm[0];
            end
            3'd4: begin
                w_word   = {in_imm[31:12], in_rd, in_opcode};
                w_reject = |in_imm[11:0];
            end
            3'd5: begin
                w_word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_reject = (in_imm != w_sext21) || in_imm[0];
            end
            default: begin
                w_reject = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= 32'h0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_count  <= 8'h0;
            r_word_count <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // finish is ignored here; start opens a fresh session
                    if (start) begin
                        r_state      <= S_RUN;
                        r_addr       <= start_addr;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_err_count  <= 8'h0;
                        r_word_count <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_err <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                        end else begin
                            r_we         <= 1'b1;
                            r_waddr      <= r_addr;
                            r_wdata      <= w_word;
                            r_addr       <= r_addr + ADDR_ONE;
                            r_word_count <= r_word_count + CNT_ONE;
                        end
                    end
                    if (finish) begin
`ifdef ENCODER_APPEND_HALT_EN
                        // ECALL goes out while in HALT, even past DEPTH
                        r_state      <= S_HALT;
                        r_we         <= 1'b1;
                        r_waddr      <= r_addr;
                        r_wdata      <= ECALL;
                        r_addr       <= r_addr + ADDR_ONE;
                        r_word_count <= r_word_count + CNT_ONE;
`else
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
`endif
                    end
                end
`ifdef ENCODER_APPEND_HALT_EN
                S_HALT: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_waddr;
    assign imem_wdata = r_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule
